rdsel_align: RTL and testbench

Parametrised load-data alignment unit, the successor of the combinational byte read select. It sits between the data-memory read port and the register-file writeback. It extracts a 1/2/4/…-byte field at any byte offset from a DATA_WIDTH word and zero- or sign-extends it. Accesses that straddle a word boundary are merged from two consecutive input beats, and the result is delivered through a registered valid/ready output.

---
 rtl/rdsel_pkg.sv | 23 ++
 rtl/rdsel_align_if.sv | 34 +++
 rtl/rdsel_extract.sv | 43 ++++
 rtl/rdsel_align.sv | 139 +++++++++++++
 tb/tb_rdsel_align.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rdsel_pkg.sv
// Shared definitions for the load-data alignment unit: size encodings,
// port-width helpers and the request FSM state type.
package rdsel_pkg;

    // Field size encodings: field is 2^size bytes wide.
    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    typedef enum logic {ST_IDLE, ST_WAIT_HI} state_t;

    // Width of the byte-offset field for a given word width.
    function automatic int ofs_w(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    // Width of the size field: must encode 0 .. ofs_w inclusive.
    function automatic int size_w(input int data_width);
        return $clog2(ofs_w(data_width) + 1);
    endfunction

endpackage

// File: rtl/rdsel_align_if.sv
// Request/result bus between the memory read port and the writeback stage.
interface rdsel_align_if #(
    parameter int DATA_WIDTH = 32
);
    import rdsel_pkg::*;

    localparam int OFS_W  = ofs_w(DATA_WIDTH);
    localparam int SIZE_W = size_w(DATA_WIDTH);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic [OFS_W-1:0]      in_offset;
    logic [SIZE_W-1:0]     in_size;
    logic                  in_signed;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_split;
    logic                  out_err;

    // Upstream memory port plus downstream consumer.
    modport master (
        output in_valid, in_data, in_offset, in_size, in_signed, out_ready,
        input  in_ready, out_valid, out_data, out_split, out_err
    );

    // Alignment unit side.
    modport slave (
        input  in_valid, in_data, in_offset, in_size, in_signed, out_ready,
        output in_ready, out_valid, out_data, out_split, out_err
    );

endinterface

// File: rtl/rdsel_extract.sv
// Combinational field extractor: shifts {hi, lo} down by the byte offset,
// keeps 2^size bytes and zero- or sign-extends them to the full word.
module rdsel_extract
    import rdsel_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    localparam int BYTES      = DATA_WIDTH / 8,
    localparam int OFS_W      = ofs_w(DATA_WIDTH),
    localparam int SIZE_W     = size_w(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] hi,
    input  logic [DATA_WIDTH-1:0] lo,
    input  logic [OFS_W-1:0]      offset,
    input  logic [SIZE_W-1:0]     size,
    input  logic                  sgn,
    output logic [DATA_WIDTH-1:0] data
);

    logic [2*DATA_WIDTH-1:0] shifted;
    logic                    sign_bit;
    int                      nbytes;

    // Byte-granular shift, then per-byte keep-or-extend.
    always_comb begin
        shifted  = {hi, lo} >> {offset, 3'b000};
        nbytes   = 1 << size;
        sign_bit = 1'b0;
        data     = '0;
        for (int b = 0; b < BYTES; b++) begin
            if (b == nbytes - 1) begin
                sign_bit = shifted[8*b+7];
            end
        end
        for (int b = 0; b < BYTES; b++) begin
            if (b < nbytes) begin
                data[8*b +: 8] = shifted[8*b +: 8];
            end else begin
                data[8*b +: 8] = {8{sgn & sign_bit}};
            end
        end
    end

endmodule

// File: rtl/rdsel_align.sv
// Load-data alignment unit: captures the first beat of a request, merges a
// second beat for fields straddling a word boundary, and presents the
// extended field through a registered valid/ready output.
module rdsel_align
    import rdsel_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter bit ALLOW_SPLIT = 1'b1
) (
    input  logic         clk,
    input  logic         srstn,
    rdsel_align_if.slave bus
);

    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int OFS_W  = ofs_w(DATA_WIDTH);
    localparam int SIZE_W = size_w(DATA_WIDTH);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;
    logic [OFS_W-1:0]      ofs_q, ofs_d;
    logic [SIZE_W-1:0]     size_q, size_d;
    logic                  sgn_q, sgn_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_split_q, out_split_d;
    logic                  out_err_q, out_err_d;

    logic                  accept;
    logic                  legal;
    logic                  straddle;
    logic [DATA_WIDTH-1:0] x_hi, x_lo, x_data;
    logic [OFS_W-1:0]      x_ofs;
    logic [SIZE_W-1:0]     x_size;
    logic                  x_sgn;

    assign bus.in_ready  = srstn && (!out_valid_q || bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign legal         = (int'(bus.in_size) <= OFS_W);
    assign straddle      = (int'(bus.in_offset) + (1 << bus.in_size)) > BYTES;

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_split = out_split_q;
    assign bus.out_err   = out_err_q;

    // Extractor operands: live beat alone in IDLE, stored low word plus live
    // high word with the stored descriptor in WAIT_HI.
    always_comb begin
        if (state_q == ST_WAIT_HI) begin
            x_hi   = bus.in_data;
            x_lo   = lo_q;
            x_ofs  = ofs_q;
            x_size = size_q;
            x_sgn  = sgn_q;
        end else begin
            x_hi   = '0;
            x_lo   = bus.in_data;
            x_ofs  = bus.in_offset;
            x_size = bus.in_size;
            x_sgn  = bus.in_signed;
        end
    end

    rdsel_extract #(.DATA_WIDTH(DATA_WIDTH)) u_extract (
        .hi     (x_hi),
        .lo     (x_lo),
        .offset (x_ofs),
        .size   (x_size),
        .sgn    (x_sgn),
        .data   (x_data)
    );

    // Next state: request FSM, capture registers and output register.
    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        ofs_d       = ofs_q;
        size_d      = size_q;
        sgn_d       = sgn_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        out_data_d  = out_data_q;
        out_split_d = out_split_q;
        out_err_d   = out_err_q;
        if (accept) begin
            if (state_q == ST_IDLE) begin
                lo_d   = bus.in_data;
                ofs_d  = bus.in_offset;
                size_d = bus.in_size;
                sgn_d  = bus.in_signed;
                if (!legal || (straddle && !ALLOW_SPLIT)) begin
                    out_valid_d = 1'b1;
                    out_data_d  = '0;
                    out_split_d = 1'b0;
                    out_err_d   = 1'b1;
                end else if (straddle) begin
                    state_d = ST_WAIT_HI;
                end else begin
                    out_valid_d = 1'b1;
                    out_data_d  = x_data;
                    out_split_d = 1'b0;
                    out_err_d   = 1'b0;
                end
            end else begin
                out_valid_d = 1'b1;
                out_data_d  = x_data;
                out_split_d = 1'b1;
                out_err_d   = 1'b0;
                state_d     = ST_IDLE;
            end
        end
    end

    // State registers; reset drops any half-merged request.
    always_ff @(posedge clk) begin
        if (!srstn) begin
            state_q     <= ST_IDLE;
            lo_q        <= '0;
            ofs_q       <= '0;
            size_q      <= '0;
            sgn_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_split_q <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            ofs_q       <= ofs_d;
            size_q      <= size_d;
            sgn_q       <= sgn_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_split_q <= out_split_d;
            out_err_q   <= out_err_d;
        end
    end

endmodule

// File: tb/tb_rdsel_align.sv
// Scoreboard bench for rdsel_align: 32-bit split, 32-bit no-split and
// 64-bit split instances driven one at a time.
module tb_rdsel_align;
    import rdsel_pkg::*;

    typedef struct packed {
        logic [63:0] d;
        logic        s;
        logic        e;
    } exp_t;

    localparam logic [63:0] W32 = 64'h0000_0000_788E_FD0C;
    localparam logic [63:0] H32 = 64'h0000_0000_1122_3344;
    localparam logic [63:0] L64 = 64'hF1E2_D3C4_788E_FD0C;
    localparam logic [63:0] H64 = 64'h99AA_BBCC_1122_3344;

    logic clk = 1'b0;
    logic srstn = 1'b0;
    logic out_rdy = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t qa[$], qb[$], qc[$];
    exp_t ea, eb, ec;

    always #5 clk = ~clk;

    rdsel_align_if #(.DATA_WIDTH(32)) ifa ();
    rdsel_align_if #(.DATA_WIDTH(32)) ifb ();
    rdsel_align_if #(.DATA_WIDTH(64)) ifc ();

    assign ifa.out_ready = out_rdy;
    assign ifb.out_ready = out_rdy;
    assign ifc.out_ready = out_rdy;

    rdsel_align #(.DATA_WIDTH(32), .ALLOW_SPLIT(1'b1)) dut_a (.clk(clk), .srstn(srstn), .bus(ifa));
    rdsel_align #(.DATA_WIDTH(32), .ALLOW_SPLIT(1'b0)) dut_b (.clk(clk), .srstn(srstn), .bus(ifb));
    rdsel_align #(.DATA_WIDTH(64), .ALLOW_SPLIT(1'b1)) dut_c (.clk(clk), .srstn(srstn), .bus(ifc));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int w);
        case (w)
            0:       return ifa.in_ready;
            1:       return ifb.in_ready;
            default: return ifc.in_ready;
        endcase
    endfunction

    function automatic logic vld(input int w);
        case (w)
            0:       return ifa.out_valid;
            1:       return ifb.out_valid;
            default: return ifc.out_valid;
        endcase
    endfunction

    task automatic drive(input int w, input logic v, input logic [63:0] d,
                         input logic [2:0] ofs, input logic [1:0] sz, input logic sg);
        case (w)
            0: begin
                ifa.in_valid = v; ifa.in_data = d[31:0]; ifa.in_offset = ofs[1:0];
                ifa.in_size = sz; ifa.in_signed = sg;
            end
            1: begin
                ifb.in_valid = v; ifb.in_data = d[31:0]; ifb.in_offset = ofs[1:0];
                ifb.in_size = sz; ifb.in_signed = sg;
            end
            default: begin
                ifc.in_valid = v; ifc.in_data = d; ifc.in_offset = ofs;
                ifc.in_size = sz; ifc.in_signed = sg;
            end
        endcase
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input int w, input logic [63:0] d, input logic [2:0] ofs,
                        input logic [1:0] sz, input logic sg, input logic push,
                        input logic [63:0] ed, input logic es, input logic ee,
                        input logic evld);
        int   n = 0;
        logic r;
        exp_t e;
        drive(w, 1'b1, d, ofs, sz, sg);
        @(negedge clk);
        r = rdy(w);
        while (!r && n < 20) begin
            @(negedge clk);
            n++;
            r = rdy(w);
        end
        if (!r) check_eq("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        if (r && push) begin
            e = '{d: ed, s: es, e: ee};
            case (w)
                0:       qa.push_back(e);
                1:       qb.push_back(e);
                default: qc.push_back(e);
            endcase
        end
        #1;
        drive(w, 1'b0, 64'd0, 3'd0, 2'd0, 1'b0);
        if (r && out_rdy) check_eq("latency_vld", 64'(vld(w)), 64'(evld));
    endtask

    always @(negedge clk) begin
        if (ifa.out_valid && ifa.out_ready) begin
            if (qa.size() == 0) check_eq("a_unexpected", 64'd1, 64'd0);
            else begin
                ea = qa.pop_front();
                check_eq("a_data", 64'(ifa.out_data), ea.d);
                check_eq("a_split", 64'(ifa.out_split), 64'(ea.s));
                check_eq("a_err", 64'(ifa.out_err), 64'(ea.e));
            end
        end
    end

    always @(negedge clk) begin
        if (ifb.out_valid && ifb.out_ready) begin
            if (qb.size() == 0) check_eq("b_unexpected", 64'd1, 64'd0);
            else begin
                eb = qb.pop_front();
                check_eq("b_data", 64'(ifb.out_data), eb.d);
                check_eq("b_split", 64'(ifb.out_split), 64'(eb.s));
                check_eq("b_err", 64'(ifb.out_err), 64'(eb.e));
            end
        end
    end

    always @(negedge clk) begin
        if (ifc.out_valid && ifc.out_ready) begin
            if (qc.size() == 0) check_eq("c_unexpected", 64'd1, 64'd0);
            else begin
                ec = qc.pop_front();
                check_eq("c_data", ifc.out_data, ec.d);
                check_eq("c_split", 64'(ifc.out_split), 64'(ec.s));
                check_eq("c_err", 64'(ifc.out_err), 64'(ec.e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int w = 0; w < 3; w++) drive(w, 1'b0, 64'd0, 3'd0, 2'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        for (int w = 0; w < 3; w++) begin
            check_eq("rst_out_valid", 64'(vld(w)), 64'd0);
            check_eq("rst_in_ready", 64'(rdy(w)), 64'd0);
        end
        check_eq("rst_a_data", 64'(ifa.out_data), 64'd0);
        check_eq("rst_a_split", 64'(ifa.out_split), 64'd0);
        check_eq("rst_a_err", 64'(ifa.out_err), 64'd0);
        check_eq("rst_c_data", ifc.out_data, 64'd0);
        srstn = 1'b1;
        @(posedge clk);
        #1;

        // 32-bit aligned extraction
        send(0, W32, 3'd0, SZ_BYTE, 1'b0, 1'b1, 64'h0000_000C, 1'b0, 1'b0, 1'b1);
        send(0, W32, 3'd1, SZ_BYTE, 1'b1, 1'b1, 64'hFFFF_FFFD, 1'b0, 1'b0, 1'b1);
        send(0, W32, 3'd1, SZ_HALF, 1'b1, 1'b1, 64'hFFFF_8EFD, 1'b0, 1'b0, 1'b1);
        send(0, W32, 3'd2, SZ_HALF, 1'b1, 1'b1, 64'h0000_788E, 1'b0, 1'b0, 1'b1);
        send(0, W32, 3'd0, SZ_WORD, 1'b1, 1'b1, 64'h788E_FD0C, 1'b0, 1'b0, 1'b1);
        send(0, W32, 3'd3, SZ_BYTE, 1'b1, 1'b1, 64'h0000_0078, 1'b0, 1'b0, 1'b1);

        // 32-bit straddling; second-beat descriptor is junk and must be ignored
        send(0, W32, 3'd3, SZ_HALF, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        send(0, H32, 3'd1, SZ_BYTE, 1'b1, 1'b1, 64'h0000_4478, 1'b1, 1'b0, 1'b1);
        send(0, W32, 3'd2, SZ_WORD, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        send(0, H32, 3'd0, SZ_BYTE, 1'b1, 1'b1, 64'h3344_788E, 1'b1, 1'b0, 1'b1);
        send(0, W32, 3'd3, SZ_HALF, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        send(0, 64'h1122_3399, 3'd0, SZ_BYTE, 1'b0, 1'b1, 64'hFFFF_9978, 1'b1, 1'b0, 1'b1);

        // illegal size
        send(0, W32, 3'd0, SZ_DWORD, 1'b0, 1'b1, 64'd0, 1'b0, 1'b1, 1'b1);

        // straddle with splitting disabled, then a normal request
        send(1, W32, 3'd3, SZ_HALF, 1'b0, 1'b1, 64'd0, 1'b0, 1'b1, 1'b1);
        send(1, W32, 3'd0, SZ_WORD, 1'b0, 1'b1, 64'h788E_FD0C, 1'b0, 1'b0, 1'b1);

        // backpressure: hold the first result for 5 cycles
        @(posedge clk);
        #1;
        out_rdy = 1'b0;
        send(0, W32, 3'd0, SZ_BYTE, 1'b0, 1'b1, 64'h0000_000C, 1'b0, 1'b0, 1'b1);
        fork
            begin
                send(0, W32, 3'd1, SZ_BYTE, 1'b1, 1'b1, 64'hFFFF_FFFD, 1'b0, 1'b0, 1'b1);
                send(0, W32, 3'd1, SZ_HALF, 1'b1, 1'b1, 64'hFFFF_8EFD, 1'b0, 1'b0, 1'b1);
                send(0, W32, 3'd2, SZ_HALF, 1'b1, 1'b1, 64'h0000_788E, 1'b0, 1'b0, 1'b1);
            end
            begin
                repeat (5) begin
                    @(negedge clk);
                    check_eq("bp_in_ready", 64'(ifa.in_ready), 64'd0);
                    check_eq("bp_out_valid", 64'(ifa.out_valid), 64'd1);
                    check_eq("bp_hold_data", 64'(ifa.out_data), 64'h0000_000C);
                end
                @(posedge clk);
                #1;
                out_rdy = 1'b1;
            end
        join
        @(posedge clk);
        #1;

        // reset while a straddling request is half-merged
        send(0, W32, 3'd3, SZ_HALF, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        srstn = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mid_rst_valid", 64'(ifa.out_valid), 64'd0);
        check_eq("mid_rst_data", 64'(ifa.out_data), 64'd0);
        check_eq("mid_rst_split", 64'(ifa.out_split), 64'd0);
        check_eq("mid_rst_err", 64'(ifa.out_err), 64'd0);
        check_eq("mid_rst_in_ready", 64'(ifa.in_ready), 64'd0);
        srstn = 1'b1;
        send(0, W32, 3'd0, SZ_BYTE, 1'b0, 1'b1, 64'h0000_000C, 1'b0, 1'b0, 1'b1);

        // 64-bit aligned
        send(2, L64, 3'd0, SZ_BYTE,  1'b0, 1'b1, 64'h0000_0000_0000_000C, 1'b0, 1'b0, 1'b1);
        send(2, L64, 3'd1, SZ_BYTE,  1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, 1'b1);
        send(2, L64, 3'd1, SZ_HALF,  1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_8EFD, 1'b0, 1'b0, 1'b1);
        send(2, L64, 3'd2, SZ_HALF,  1'b1, 1'b1, 64'h0000_0000_0000_788E, 1'b0, 1'b0, 1'b1);
        send(2, L64, 3'd0, SZ_WORD,  1'b0, 1'b1, 64'h0000_0000_788E_FD0C, 1'b0, 1'b0, 1'b1);
        send(2, L64, 3'd4, SZ_WORD,  1'b1, 1'b1, 64'hFFFF_FFFF_F1E2_D3C4, 1'b0, 1'b0, 1'b1);
        send(2, L64, 3'd0, SZ_DWORD, 1'b1, 1'b1, 64'hF1E2_D3C4_788E_FD0C, 1'b0, 1'b0, 1'b1);

        // 64-bit straddling
        send(2, L64, 3'd7, SZ_HALF,  1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        send(2, H64, 3'd0, SZ_BYTE,  1'b0, 1'b1, 64'h0000_0000_0000_44F1, 1'b1, 1'b0, 1'b1);
        send(2, L64, 3'd6, SZ_WORD,  1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        send(2, H64, 3'd0, SZ_BYTE,  1'b0, 1'b1, 64'h0000_0000_3344_F1E2, 1'b1, 1'b0, 1'b1);
        send(2, L64, 3'd4, SZ_DWORD, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        send(2, H64, 3'd0, SZ_BYTE,  1'b0, 1'b1, 64'h1122_3344_F1E2_D3C4, 1'b1, 1'b0, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        check_eq("a_queue_empty", 64'(qa.size()), 64'd0);
        check_eq("b_queue_empty", 64'(qb.size()), 64'd0);
        check_eq("c_queue_empty", 64'(qc.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
